al_accel_quant_vec: RTL and testbench

- Multi-lane, fully pipelined requantization unit for the CNN accelerator.
- Converts int32 accumulator outputs to clamped int8 activations.
- Per lane: fixed-point multiply by a Q31 multiplier (saturating rounding doubling high multiply), rounding right shift, output zero-point add, clamp to [act_min, act_max].
- Sits between the MAC array accumulator bank and the activation write-back buffer, with valid/ready flow control on both sides.

---
 rtl/al_accel_quant_vec.sv | 148 ++++++++++++++
 tb/tb_al_accel_quant_vec.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/al_accel_quant_vec.sv
// Multi-lane requantization pipeline: int32 accumulators -> clamped OUT_W activations.
// Per lane: Q31 saturating rounding doubling high multiply, rounding shift, zero-point add, clamp.
`timescale 1ns/1ps
module al_accel_quant_vec #(
    parameter int LANES = 4,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cfg_per_channel,
    input  logic [32*LANES-1:0]      quant_muler,
    input  logic [5*LANES-1:0]       quant_rshift,
    input  logic [OUT_W-1:0]         out_zp,
    input  logic [OUT_W-1:0]         act_min,
    input  logic [OUT_W-1:0]         act_max,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [32*LANES-1:0]      quant_di,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W*LANES-1:0]   quant_do
);

    localparam logic signed [63:0] NUDGE_POS = 64'sd1073741824;
    localparam logic signed [63:0] NUDGE_NEG = -64'sd1073741823;

    logic stall;
    logic v1, v2, v3, v4;

    logic signed [63:0] s1_ab  [LANES];
    logic               s1_sat [LANES];
    logic [4:0]         s1_sh  [LANES];
    logic [4:0]         s2_sh  [LANES];
    logic signed [31:0] s2_srd [LANES];
    logic signed [31:0] s3_r   [LANES];
    logic [OUT_W*LANES-1:0] s4_do;

    logic [OUT_W-1:0] s1_zp, s1_min, s1_max;
    logic [OUT_W-1:0] s2_zp, s2_min, s2_max;
    logic [OUT_W-1:0] s3_zp, s3_min, s3_max;

    logic [31:0]        m_sel  [LANES];
    logic [4:0]         sh_sel [LANES];
    logic signed [63:0] ab_n   [LANES];
    logic               sat_n  [LANES];
    logic signed [63:0] x2     [LANES];
    logic signed [31:0] srd_n  [LANES];
    logic [31:0]        mask3  [LANES];
    logic [31:0]        rem3   [LANES];
    logic [31:0]        thr3   [LANES];
    logic signed [31:0] r_n    [LANES];
    logic signed [32:0] t4     [LANES];
    logic signed [32:0] lo4    [LANES];
    logic signed [32:0] hi4    [LANES];
    logic signed [32:0] cl4    [LANES];
    logic [OUT_W*LANES-1:0] do_n;

    // A single global stall freezes every stage so bubbles keep their position.
    assign stall     = v4 && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = v4;
    assign quant_do  = s4_do;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            m_sel[i]  = cfg_per_channel ? quant_muler[32*i +: 32] : quant_muler[31:0];
            sh_sel[i] = cfg_per_channel ? quant_rshift[5*i +: 5] : quant_rshift[4:0];
            ab_n[i]   = $signed({{32{quant_di[32*i+31]}}, quant_di[32*i +: 32]}) *
                        $signed({{32{m_sel[i][31]}}, m_sel[i]});
            sat_n[i]  = (quant_di[32*i +: 32] == 32'h8000_0000) && (m_sel[i] == 32'h8000_0000);
        end
    end

    // Bits [62:31] are the floor of x/2^31; negative values with a nonzero
    // remainder are bumped by one to truncate toward zero instead.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            x2[i]    = s1_ab[i] + (s1_ab[i][63] ? NUDGE_NEG : NUDGE_POS);
            srd_n[i] = x2[i][62:31];
            if (x2[i][63] && (x2[i][30:0] != 31'd0)) begin
                srd_n[i] = srd_n[i] + 32'sd1;
            end
            if (s1_sat[i]) begin
                srd_n[i] = 32'sh7FFF_FFFF;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mask3[i] = (32'd1 << s2_sh[i]) - 32'd1;
            rem3[i]  = s2_srd[i] & mask3[i];
            thr3[i]  = (mask3[i] >> 1) + {31'd0, s2_srd[i][31]};
            r_n[i]   = (s2_srd[i] >>> s2_sh[i]) + ((rem3[i] > thr3[i]) ? 32'sd1 : 32'sd0);
        end
    end

    // Max bound is applied after min so an inverted range yields act_max.
    always_comb begin
        do_n = '0;
        for (int i = 0; i < LANES; i++) begin
            t4[i]  = {s3_r[i][31], s3_r[i]} + {{(33-OUT_W){s3_zp[OUT_W-1]}}, s3_zp};
            lo4[i] = {{(33-OUT_W){s3_min[OUT_W-1]}}, s3_min};
            hi4[i] = {{(33-OUT_W){s3_max[OUT_W-1]}}, s3_max};
            cl4[i] = (t4[i] < lo4[i]) ? lo4[i] : t4[i];
            do_n[OUT_W*i +: OUT_W] = (cl4[i] > hi4[i]) ? hi4[i][OUT_W-1:0] : cl4[i][OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            v4    <= 1'b0;
            s4_do <= '0;
            s1_zp <= '0; s1_min <= '0; s1_max <= '0;
            s2_zp <= '0; s2_min <= '0; s2_max <= '0;
            s3_zp <= '0; s3_min <= '0; s3_max <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_ab[i]  <= '0;
                s1_sat[i] <= 1'b0;
                s1_sh[i]  <= '0;
                s2_sh[i]  <= '0;
                s2_srd[i] <= '0;
                s3_r[i]   <= '0;
            end
        end else if (!stall) begin
            v1    <= in_valid;
            v2    <= v1;
            v3    <= v2;
            v4    <= v3;
            s4_do <= do_n;
            s1_zp <= out_zp; s1_min <= act_min; s1_max <= act_max;
            s2_zp <= s1_zp;  s2_min <= s1_min;  s2_max <= s1_max;
            s3_zp <= s2_zp;  s3_min <= s2_min;  s3_max <= s2_max;
            for (int i = 0; i < LANES; i++) begin
                s1_ab[i]  <= ab_n[i];
                s1_sat[i] <= sat_n[i];
                s1_sh[i]  <= sh_sel[i];
                s2_sh[i]  <= s1_sh[i];
                s2_srd[i] <= srd_n[i];
                s3_r[i]   <= r_n[i];
            end
        end
    end

endmodule

// File: tb/tb_al_accel_quant_vec.sv
// Self-checking bench for al_accel_quant_vec: vector table, random beats against a
// reference model, backpressure stream and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_al_accel_quant_vec;

    localparam int LANES = 4;
    localparam int OUT_W = 8;
    localparam int IMIN  = int'(32'h8000_0000);
    localparam int IMAX  = 2147483647;
    localparam int MB    = 2039693188;
    localparam int MX    = 2147483647;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cfg_per_channel;
    logic [127:0] quant_muler;
    logic [19:0]  quant_rshift;
    logic [7:0]   out_zp, act_min, act_max;
    logic         in_valid, in_ready;
    logic [127:0] quant_di;
    logic         out_valid, out_ready;
    logic [31:0]  quant_do;

    al_accel_quant_vec #(.LANES(LANES), .OUT_W(OUT_W)) dut (
        .clk(clk), .resetn(resetn), .cfg_per_channel(cfg_per_channel),
        .quant_muler(quant_muler), .quant_rshift(quant_rshift), .out_zp(out_zp),
        .act_min(act_min), .act_max(act_max), .in_valid(in_valid), .in_ready(in_ready),
        .quant_di(quant_di), .out_valid(out_valid), .out_ready(out_ready), .quant_do(quant_do)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           per_ch;
        logic [127:0] di;
        logic [127:0] m;
        logic [19:0]  sh;
        logic [7:0]   zp, mn, mx;
        logic [31:0]  exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          cyc;
        bit          chk_lat;
    } sb_t;

    sb_t         sb_q[$];
    vec_t        tbl[11];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] cur_exp;
    bit          cur_lat;
    bit          xfer;
    bit          bp_en = 0;
    int          bp_k = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_do;

    function automatic logic [7:0] model_lane(int di, int m, int sh, int zp, int mn, int mx);
        longint ab, x, srd, r, t, half, div;
        if (di == IMIN && m == IMIN) begin
            srd = 64'sd2147483647;
        end else begin
            ab  = longint'(di) * longint'(m);
            x   = (ab >= 0) ? ab + 64'sd1073741824 : ab + 64'sd1 - 64'sd1073741824;
            srd = x / 64'sd2147483648;
        end
        if (sh == 0) begin
            r = srd;
        end else begin
            half = longint'(1) <<< (sh - 1);
            div  = longint'(1) <<< sh;
            r = (srd >= 0) ? (srd + half) / div : -((-srd + half) / div);
        end
        t = r + longint'(zp);
        if (t < mn) t = mn;
        if (t > mx) t = mx;
        return t[7:0];
    endfunction

    function automatic vec_t mk(bit per, int d0, int d1, int d2, int d3,
                                int m0, int m1, int m2, int m3,
                                int s0, int s1, int s2, int s3,
                                int zp, int mn, int mx,
                                int e0, int e1, int e2, int e3);
        vec_t v;
        v.per_ch = per;
        v.di     = {d3, d2, d1, d0};
        v.m      = {m3, m2, m1, m0};
        v.sh     = {s3[4:0], s2[4:0], s1[4:0], s0[4:0]};
        v.zp     = zp[7:0];
        v.mn     = mn[7:0];
        v.mx     = mx[7:0];
        v.exp    = {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
        return v;
    endfunction

    function automatic vec_t mk_rand();
        vec_t v;
        int   di, m, sh, li;
        v.per_ch = 1'($urandom_range(0, 1));
        v.zp = 8'($urandom_range(0, 255));
        v.mn = 8'($urandom_range(0, 255));
        v.mx = 8'($urandom_range(0, 255));
        for (int i = 0; i < LANES; i++) begin
            v.di[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200000) - 100000);
            v.m[32*i +: 32]  = $urandom;
            v.sh[5*i +: 5]   = 5'($urandom_range(0, 31));
        end
        for (int i = 0; i < LANES; i++) begin
            li = v.per_ch ? i : 0;
            di = int'(v.di[32*i +: 32]);
            m  = int'(v.m[32*li +: 32]);
            sh = int'({27'd0, v.sh[5*li +: 5]});
            v.exp[8*i +: 8] = model_lane(di, m, sh, int'($signed(v.zp)),
                                         int'($signed(v.mn)), int'($signed(v.mx)));
        end
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a negedge once inputs are driven; samples mid-cycle, scores, waits for next negedge.
    task automatic cycle_end();
        sb_t e;
        if (bp_en) begin
            out_ready = (bp_k % 3 == 0);
            bp_k++;
        end
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
        if (prev_stall) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold", quant_do, prev_do);
        end
        xfer = in_valid && in_ready;
        if (xfer) sb_q.push_back('{cur_exp, cyc, cur_lat});
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got %h, expected no beat", quant_do);
            end else begin
                e = sb_q.pop_front();
                check("quant_do", quant_do, e.exp);
                if (e.chk_lat) check("latency", cyc - e.cyc, 32'd4);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_do    = quant_do;
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_stimulus(vec_t v, bit lat);
        bit done = 0;
        cfg_per_channel = v.per_ch;
        quant_di        = v.di;
        quant_muler     = v.m;
        quant_rshift    = v.sh;
        out_zp          = v.zp;
        act_min         = v.mn;
        act_max         = v.mx;
        in_valid        = 1'b1;
        cur_exp         = v.exp;
        cur_lat         = lat;
        for (int k = 0; k < 20; k++) begin
            cycle_end();
            if (xfer) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_accept: got in_ready low for 20 cycles, expected transfer");
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 40 && sb_q.size() > 0; k++) cycle_end();
        check("drain", sb_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1, 4581, 4581, 4581, 4581, MB, MB, MB, MB, 8, 8, 8, 8, 0, -128, 127, 17, 17, 17, 17);
        tbl[1]  = mk(1, 4581, -4581, 384, -384, MB, MB, MX, MX, 8, 8, 8, 8, 0, -128, 127, 17, -17, 2, -2);
        tbl[2]  = mk(1, IMIN, 4581, 0, -4581, IMIN, MB, MB, MB, 0, 8, 8, 8, 0, -128, 127, 127, 17, 0, -17);
        tbl[3]  = mk(1, IMIN, 4581, 4581, 4581, IMIN, MB, MB, MB, 0, 8, 8, 8, -128, -128, 127, 127, -111, -111, -111);
        tbl[4]  = mk(1, 4581, IMIN, -4581, 0, MB, IMIN, MB, MB, 8, 0, 8, 8, -128, -128, 10, -111, 10, -128, -128);
        tbl[5]  = mk(1, 4581, -4581, IMIN, 0, MB, MB, IMIN, MB, 8, 8, 0, 8, 0, -128, 10, 10, -17, 10, 0);
        tbl[6]  = mk(0, 4581, 4581, 4581, 4581, MB, 0, 0, 0, 8, 0, 0, 0, 0, -128, 127, 17, 17, 17, 17);
        tbl[7]  = mk(1, 0, 4581, -4581, 100000, MB, MB, MB, MB, 8, 8, 8, 8, 0, 20, -20, -20, -20, -20, -20);
        tbl[8]  = mk(1, -2000000000, 2000000000, 1000, 20, MX, MX, MX, MX, 0, 0, 3, 3, 5, -100, 100, -100, 100, 100, 8);
        tbl[9]  = mk(1, IMAX, IMIN, 1, -1, MX, MX, MX, MX, 31, 31, 31, 31, 0, -128, 127, 1, -1, 0, 0);
        tbl[10] = mk(1, -640, 640, -639, -641, MX, MX, MX, MX, 8, 8, 8, 8, 3, -128, 127, 0, 6, 1, 0);

        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_per_channel = 1'b0;
        quant_di = '0; quant_muler = '0; quant_rshift = '0;
        out_zp = '0; act_min = '0; act_max = '0; cur_exp = '0; cur_lat = 0;
        #2;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_quant_do", quant_do, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        $display("[TB] table vectors, back to back");
        for (int i = 0; i < 11; i++) apply_stimulus(tbl[i], 1);
        drain();

        $display("[TB] random beats against model");
        for (int i = 0; i < 30; i++) apply_stimulus(mk_rand(), 1);
        drain();

        $display("[TB] backpressure stream");
        bp_en = 1; bp_k = 0;
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(mk(1, k*256, k*256, k*256, k*256, MX, MX, MX, MX, 8, 8, 8, 8,
                              0, -128, 127, k, k, k, k), 0);
        end
        drain();
        bp_en = 0; out_ready = 1'b1;
        cycle_end();

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 3; i++) apply_stimulus(tbl[i], 1);
        in_valid = 1'b0;
        cycle_end();
        #1;
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, out_valid}, 32'd0);
        check("async_reset_do", quant_do, 32'd0);
        #9;
        resetn = 1'b1;
        sb_q.delete();
        prev_stall = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            cycle_end();
            check("no_stale", {31'd0, out_valid}, 32'd0);
        end
        apply_stimulus(tbl[1], 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
